// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   UART transmitter fed by a FIFO. Producers write words over a valid/ready
//   port. Each word is sent as one frame: a start bit, DATA_BITS data bits
//   LSB first, an optional parity bit, then STOP_BITS stop bits. When the
//   FIFO holds more words, frames follow each other with no idle gap.
//
// Ports
//   clk         system clock, rising edge
//   reset_n     asynchronous reset, active low
//   tx_data     word to enqueue (DATA_BITS wide)
//   tx_valid    tx_data is valid this cycle
//   tx_ready    FIFO not full; a word is accepted when tx_valid and tx_ready
//   tx_out      serial line, registered, idles high
//   tx_busy     a frame is in progress or the FIFO is not empty
//   tx_done     one-cycle pulse during the last clock of each frame's last stop bit
//   fifo_count  number of words held in the FIFO
module uart_tx_fifo #(
    parameter int CLK_FRQ    = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,   // 0 none, 1 odd, 2 even
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_out,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CYCLE = CLK_FRQ / BAUD_RATE;
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic [15:0] CYC_M1   = 16'(CYCLE - 1);
    localparam logic [3:0]  DATA_M1  = 4'(DATA_BITS - 1);
    localparam logic [3:0]  STOP_M1  = 4'(STOP_BITS - 1);
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // Out-of-range parameters stop elaboration.
    if (CYCLE < 2 || CYCLE > 65535) begin : g_bad_cycle
        $error("uart_tx_fifo: CLK_FRQ/BAUD_RATE must be 2..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, >= 2");
    end

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0] head;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic [2:0]           state;
    logic [15:0]          baud_cnt;
    logic [3:0]           bit_cnt;
    logic                 baud_last, stop_last, fifo_nempty, push, pop;

    assign head        = mem[rd_ptr];
    assign fifo_nempty = (fifo_count != '0);
    assign baud_last   = (baud_cnt == CYC_M1);
    assign stop_last   = (state == S_STOP) && baud_last && (bit_cnt == STOP_M1);

    // A word is popped either from idle or on the last stop clock, which is
    // what makes consecutive frames abut with no idle cycle.
    assign pop      = fifo_nempty && ((state == S_IDLE) || stop_last);
    assign push     = tx_valid && tx_ready;
    assign tx_ready = (fifo_count < DEPTH_C);
    assign tx_busy  = (state != S_IDLE) || fifo_nempty;
    assign tx_done  = stop_last;

    // Storage carries no reset; occupancy is tracked by pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= fifo_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // tx_out is loaded with the level of the bit that starts on the same
    // edge as the state change, so the line follows the FSM with no lag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            tx_out   <= 1'b1;
        end else begin
            if (pop) begin
                shreg   <= head;
                // odd: ones(data)+parity is odd; even: that total is even
                par_bit <= (PARITY == 1) ? ~^head : ^head;
            end
            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (fifo_nempty) begin
                        state  <= S_START;
                        tx_out <= 1'b0;
                    end else begin
                        tx_out <= 1'b1;
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= S_DATA;
                        tx_out   <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_cnt == DATA_M1) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                state  <= S_PARITY;
                                tx_out <= par_bit;
                            end else begin
                                state  <= S_STOP;
                                tx_out <= 1'b1;
                            end
                        end else begin
                            // shreg[0] is always the bit on the line
                            bit_cnt <= bit_cnt + 4'd1;
                            shreg   <= shreg >> 1;
                            tx_out  <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                S_PARITY: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= S_STOP;
                        tx_out   <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_cnt == STOP_M1) begin
                            bit_cnt <= '0;
                            if (fifo_nempty) begin
                                state  <= S_START;
                                tx_out <= 1'b0;
                            end else begin
                                state  <= S_IDLE;
                                tx_out <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    tx_out <= 1'b1;
                end
            endcase
        end
    end

endmodule
